// File: rtl/td4_exec_controller.sv
// rtl/td4_exec_controller.sv - TD4 execution controller: writable program RAM, run/halt/step sequencing, byte loader
module td4_exec_controller #(
    parameter int ADDR_W   = 4,
    parameter int DATA_W   = 8,
    parameter int STEP_DIV = 4
) (
    input  logic              CLK,
    input  logic              CLR,
    input  logic              cmd_valid,
    input  logic [1:0]        cmd_op,
    output logic              cmd_ready,
    input  logic              ld_valid,
    input  logic [DATA_W-1:0] ld_data,
    output logic              ld_ready,
    input  logic [ADDR_W-1:0] cpu_A,
    output logic [DATA_W-1:0] cpu_D,
    output logic              cpu_en,
    output logic              cpu_clr_n,
    output logic [2:0]        mode
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int PW    = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [PW-1:0]     PRESC_MAX = PW'(STEP_DIV - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic [2:0] {
        S_HALT    = 3'd0,
        S_RUN     = 3'd1,
        S_STEP    = 3'd2,
        S_LOAD    = 3'd3,
        S_RELEASE = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   wptr_q, wptr_d;
    logic [PW-1:0]       presc_q, presc_d;
    logic                cmd_ready_q, cmd_ready_d;
    logic                ld_ready_q, ld_ready_d;
    logic                cpu_en_q, cpu_en_d;
    logic                cpu_clr_n_q, cpu_clr_n_d;
    logic [DATA_W-1:0]   mem_q [DEPTH];
    logic                cmd_acc;
    logic                ld_acc;

    assign cmd_acc = cmd_valid & cmd_ready_q;
    assign ld_acc  = ld_valid & ld_ready_q;

    always_comb begin
        state_d = state_q;
        wptr_d  = wptr_q;
        presc_d = presc_q;
        case (state_q)
            S_HALT: begin
                if (cmd_acc) begin
                    case (cmd_op)
                        2'b00: begin
                            state_d = S_RUN;
                            presc_d = '0;
                        end
                        2'b10: state_d = S_STEP;
                        2'b11: begin
                            state_d = S_LOAD;
                            wptr_d  = '0;
                        end
                        default: state_d = S_HALT;
                    endcase
                end
            end
            S_RUN: begin
                presc_d = (presc_q == PRESC_MAX) ? '0 : presc_q + PW'(1);
                if (cmd_acc) begin
                    case (cmd_op)
                        2'b01: state_d = S_HALT;
                        2'b11: begin
                            state_d = S_LOAD;
                            wptr_d  = '0;
                        end
                        default: state_d = S_RUN;
                    endcase
                end
            end
            S_STEP:    state_d = S_HALT;
            S_LOAD: begin
                if (ld_acc) begin
                    wptr_d = wptr_q + ADDR_W'(1);
                    if (wptr_q == LAST_ADDR) begin
                        state_d = S_RELEASE;
                    end
                end
            end
            S_RELEASE: state_d = S_HALT;
            default:   state_d = S_HALT;
        endcase

        // Outputs are registered from the next state so they line up with mode.
        cmd_ready_d = (state_d == S_HALT) || (state_d == S_RUN);
        ld_ready_d  = (state_d == S_LOAD);
        cpu_clr_n_d = !((state_d == S_LOAD) || (state_d == S_RELEASE));
        cpu_en_d    = (state_d == S_STEP) ||
                      ((state_d == S_RUN) && (presc_d == PRESC_MAX));
    end

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            state_q     <= S_HALT;
            wptr_q      <= '0;
            presc_q     <= '0;
            cmd_ready_q <= 1'b1;
            ld_ready_q  <= 1'b0;
            cpu_en_q    <= 1'b0;
            cpu_clr_n_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            wptr_q      <= wptr_d;
            presc_q     <= presc_d;
            cmd_ready_q <= cmd_ready_d;
            ld_ready_q  <= ld_ready_d;
            cpu_en_q    <= cpu_en_d;
            cpu_clr_n_q <= cpu_clr_n_d;
        end
    end

    // Program RAM is flop-based so reset can wipe it in one shot.
    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (ld_acc) begin
            mem_q[wptr_q] <= ld_data;
        end
    end

    assign cpu_D     = ((state_q == S_LOAD) || (state_q == S_RELEASE)) ? '0 : mem_q[cpu_A];
    assign cmd_ready = cmd_ready_q;
    assign ld_ready  = ld_ready_q;
    assign cpu_en    = cpu_en_q;
    assign cpu_clr_n = cpu_clr_n_q;
    assign mode      = state_q;

endmodule

// File: doc/td4_exec_controller.md
Name: td4_exec_controller

Overview:
Execution controller for the 4-bit TD4 core. It owns a writable 16x8 program RAM that replaces the fixed program ROM, and serves it to the CPU fetch port. It also sequences the CPU through run, halt and single-step modes via a one-cycle advance strobe. A byte-stream loader port shares the RAM with the CPU: the CPU is held in clear for the whole load, then released and halted.

Parameters:
ADDR_W, 4, program address width (RAM depth 2**ADDR_W)
DATA_W, 8, instruction width
STEP_DIV, 4, RUN-mode clocks per instruction advance; must be >= 1

Ports:
CLK  in  1  system clock, rising edge
CLR  in  1  asynchronous active-low reset
cmd_valid  in  1  command request
cmd_op  in  2  00 RUN, 01 HALT, 10 STEP, 11 LOAD
cmd_ready  out  1  command accepted when cmd_valid & cmd_ready at a rising edge
ld_valid  in  1  load byte valid
ld_data  in  DATA_W  load byte
ld_ready  out  1  load byte accepted when ld_valid & ld_ready at a rising edge
cpu_A  in  ADDR_W  CPU fetch address
cpu_D  out  DATA_W  instruction to CPU
cpu_en  out  1  CPU advances exactly one instruction on each edge where cpu_en=1
cpu_clr_n  out  1  active-low clear to CPU
mode  out  3  current state encoding: HALT=0, RUN=1, STEP=2, LOAD=3, RELEASE=4

Behaviour:
- CLR low (asynchronous): state HALT; all RAM words = 0x00; wptr=0; prescaler=0; cpu_en=0; cpu_clr_n=1; ld_ready=0; cmd_ready=1.
- All outputs are registered except cpu_D.
- cpu_D = mem[cpu_A], combinational, in every state except LOAD and RELEASE, where cpu_D = 0x00.
- cmd_ready=1 in HALT and RUN; cmd_ready=0 in STEP, LOAD and RELEASE.
- HALT state:
  - RUN command -> RUN, prescaler cleared to 0.
  - STEP command -> STEP.
  - LOAD command -> LOAD, wptr=0, cpu_clr_n=0 and ld_ready=1 from the next cycle.
  - HALT command -> consumed, no effect.
- RUN state:
  - Prescaler counts 0..STEP_DIV-1, then wraps.
  - cpu_en=1 for exactly one cycle per wrap.
  - First pulse is high during the STEP_DIV-th cycle after the accepting edge.
  - STEP_DIV=1: cpu_en stays high continuously in RUN.
  - HALT command -> HALT; no further pulses. A pulse already registered for the current cycle is still issued.
  - LOAD command -> LOAD, same entry as from HALT. cpu_en is forced 0 from the next cycle.
  - RUN and STEP commands -> consumed, ignored.
- STEP state:
  - Lasts exactly one cycle, with cpu_en=1 during that cycle.
  - Then returns to HALT.
  - STEP accepted at edge N: cpu_en high between edges N and N+1, back in HALT after edge N+1.
- LOAD state:
  - cpu_clr_n=0, cpu_en=0, ld_ready=1.
  - Each accepted byte is written to mem[wptr], then wptr increments.
  - ld_valid gaps are allowed; no timeout.
  - After the 2**ADDR_W-th byte is accepted: ld_ready=0, go to RELEASE. wptr wraps to 0.
- RELEASE state:
  - Lasts one cycle, with cpu_clr_n held 0.
  - Then HALT with cpu_clr_n=1, so the CPU restarts from address 0.
- ld_valid outside LOAD is ignored; nothing is written.
- CLR low mid-load aborts the load: HALT, RAM cleared, wptr=0.
- Simultaneous cmd_valid and ld_valid in LOAD: the command is not accepted (cmd_ready=0); the byte is taken.
- An illegal mode encoding is unreachable; decode any such value as HALT.

Test Plan:
- Reset values: pulse CLR low mid-cycle -> outputs reach their reset values immediately, without waiting for a clock edge (mode=0, cpu_en=0, cpu_clr_n=1, cmd_ready=1, ld_ready=0); sweep cpu_A over 0..15 -> cpu_D=0x00 for every address.
- Load and release:
  - Stimulus: issue LOAD, then stream bytes 0x00..0x0F XOR 0xB0, with ld_valid dropped for 2 cycles after byte 5.
  - Required: cpu_clr_n=0 throughout the load and for one extra cycle after byte 16, then returns to 1.
  - Required: afterwards cpu_A=k reads cpu_D=0xB0^k; mode=0.
- Single step: from HALT, issue STEP three times -> exactly 3 single-cycle cpu_en pulses; cmd_ready=0 during each pulse cycle.
- Run pacing:
  - Stimulus: STEP_DIV=4; issue RUN; hold for 20 cycles; then HALT.
  - Required: cpu_en has period 4 with its first pulse 4 cycles after acceptance, 5 pulses in total; zero pulses after HALT.
  - Repeat with STEP_DIV=1 -> cpu_en stays high continuously while in RUN.
- LOAD during RUN: issue LOAD while cpu_en is pulsing -> cpu_en=0 and cpu_clr_n=0 from the next cycle; a RUN command issued during the load is not accepted.
- Reset mid-load: write 7 bytes, then pulse CLR low -> mode=0, every address reads 0x00; a fresh 16-byte load then completes normally.
